st_bus_rx_framer: RTL and testbench

//  Receive side of the DT serial link: samples data_from_dt on c4, aligns to the active-low f0

---
 rtl/st_bus_pkg.sv | 23 ++
 rtl/st_bus_bank_ram.sv | 27 ++
 rtl/st_bus_rx_framer.sv | 141 ++++++++++++++
 tb/tb_st_bus_rx_framer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/st_bus_pkg.sv
// Shared framing constants and FSM encoding for the DT serial link.
// Used by the receive framer and by converter-side blocks.
package st_bus_pkg;

    localparam int SLOTS_DEF = 32;
    localparam int CPB_DEF   = 2;
    localparam int MISS_DEF  = 2;
    localparam int BYTE_BITS = 8;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } st_e;

    function automatic int slot_clks(input int cpb);
        return BYTE_BITS * cpb;
    endfunction

    function automatic int frame_len(input int slots, input int cpb);
        return slots * slot_clks(cpb);
    endfunction

endpackage

// File: rtl/st_bus_bank_ram.sv
// Ping-pong slot buffer: 2*SLOTS bytes, one write port, one registered read port.
// Ports: clk_i/rst_ni, we_i/waddr_i/wdata_i write {bank,slot}, raddr_i -> rdata_o (1 cycle).
module st_bus_bank_ram #(
    parameter int SLOTS = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [$clog2(SLOTS):0] waddr_i,
    input  logic [7:0]             wdata_i,
    input  logic [$clog2(SLOTS):0] raddr_i,
    output logic [7:0]             rdata_o
);

    logic [7:0] mem_q [2*SLOTS];

    // Array has no reset; only the output register does.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_o <= '0;
        else         rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/st_bus_rx_framer.sv
// DT link receive framer: aligns to f0, packs timeslots into a ping-pong buffer.
// Ports: c4/reset_in_rg, f0, data_from_dt, int_ack, rd_addr -> rd_data, cpu_int, overrun, sync_err, in_sync.
module st_bus_rx_framer
    import st_bus_pkg::*;
#(
    parameter int SLOTS        = SLOTS_DEF,
    parameter int CLKS_PER_BIT = CPB_DEF,
    parameter int MISS_LIMIT   = MISS_DEF
) (
    input  logic                     c4,
    input  logic                     reset_in_rg,
    input  logic                     f0,
    input  logic                     data_from_dt,
    input  logic                     int_ack,
    input  logic [$clog2(SLOTS)-1:0] rd_addr,
    output logic [7:0]               rd_data,
    output logic                     cpu_int,
    output logic                     overrun,
    output logic                     sync_err,
    output logic                     in_sync
);

    localparam int AW = $clog2(SLOTS);
    localparam int SC = slot_clks(CLKS_PER_BIT);
    localparam int FL = frame_len(SLOTS, CLKS_PER_BIT);
    localparam int CW = $clog2(FL);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    st_e           state_q;
    logic [CW-1:0] cnt_q;
    // Only the 7 older bits are kept; the 8th comes straight from the pin.
    logic [6:0]    sreg_q;
    logic          wr_bank_q;
    logic [MW-1:0] miss_q;
    logic [MW-1:0] miss_d;
    logic          cpu_int_q;
    logic          overrun_q;
    logic          sync_err_q;
    logic          in_sync_q;

    logic          sync_st;
    logic          last;
    logic          bit_smp;
    logic          byte_end;
    logic          f0_hit;
    logic          lost;
    logic          swap;
    logic          we;
    logic [AW-1:0] wslot;

    assign sync_st  = (state_q == SYNC);
    assign f0_hit   = ~f0;
    assign last     = (cnt_q == CW'(FL - 1));
    assign bit_smp  = ((cnt_q % CW'(CLKS_PER_BIT)) == CW'(CLKS_PER_BIT - 1));
    assign byte_end = ((cnt_q % CW'(SC)) == CW'(SC - 1));
    assign wslot    = AW'(cnt_q / CW'(SC));
    assign miss_d   = miss_q + MW'(1);

    // Frame end without f0 that exhausts the miss budget drops sync instead of swapping.
    assign lost = sync_st && last && !f0_hit && (miss_d == MW'(MISS_LIMIT));
    assign swap = sync_st && last && !lost;
    // An early f0 discards the partial frame, so its slot write is suppressed.
    assign we   = sync_st && byte_end && (last || !f0_hit);

    always_ff @(posedge c4 or negedge reset_in_rg) begin
        if (!reset_in_rg) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            sreg_q     <= '0;
            wr_bank_q  <= 1'b0;
            miss_q     <= '0;
            cpu_int_q  <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
            in_sync_q  <= 1'b0;
        end else begin
            sync_err_q <= 1'b0;
            if (sync_st && bit_smp) sreg_q <= {sreg_q[5:0], data_from_dt};

            unique case (state_q)
                HUNT: begin
                    if (f0_hit) begin
                        state_q   <= SYNC;
                        in_sync_q <= 1'b1;
                        cnt_q     <= '0;
                        miss_q    <= '0;
                    end
                end
                SYNC: begin
                    if (last) begin
                        cnt_q <= '0;
                        if (f0_hit) begin
                            miss_q <= '0;
                        end else if (lost) begin
                            state_q   <= HUNT;
                            in_sync_q <= 1'b0;
                            miss_q    <= '0;
                        end else begin
                            miss_q <= miss_d;
                        end
                    end else if (f0_hit) begin
                        sync_err_q <= 1'b1;
                        cnt_q      <= '0;
                        miss_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase

            if (swap) begin
                wr_bank_q <= ~wr_bank_q;
                cpu_int_q <= 1'b1;
                // Set wins over a simultaneous ack, but the ack still clears overrun.
                overrun_q <= !int_ack && (overrun_q || cpu_int_q);
            end else if (int_ack) begin
                cpu_int_q <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    // Read port always addresses the bank not being written, using the pre-swap bank.
    st_bus_bank_ram #(
        .SLOTS(SLOTS)
    ) u_ram (
        .clk_i  (c4),
        .rst_ni (reset_in_rg),
        .we_i   (we),
        .waddr_i({wr_bank_q, wslot}),
        .wdata_i({sreg_q, data_from_dt}),
        .raddr_i({~wr_bank_q, rd_addr}),
        .rdata_o(rd_data)
    );

    assign cpu_int  = cpu_int_q;
    assign overrun  = overrun_q;
    assign sync_err = sync_err_q;
    assign in_sync  = in_sync_q;

endmodule

// File: tb/tb_st_bus_rx_framer.sv
// Bench for st_bus_rx_framer: directed scenarios plus random traffic,
// checked every cycle against a frame-level model.
module tb_st_bus_rx_framer;

    localparam int SLOTS = 32;
    localparam int CPB   = 2;
    localparam int SC    = 8 * CPB;
    localparam int FL    = SLOTS * SC;
    localparam int MISS  = 2;
    localparam int AW    = $clog2(SLOTS);

    logic          c4 = 1'b0;
    logic          reset_in_rg = 1'b1;
    logic          f0 = 1'b1;
    logic          data_from_dt = 1'b0;
    logic          int_ack = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          cpu_int;
    logic          overrun;
    logic          sync_err;
    logic          in_sync;

    int checks = 0;
    int errors = 0;

    logic [7:0] pay [SLOTS];

    st_bus_rx_framer dut (
        .c4          (c4),
        .reset_in_rg (reset_in_rg),
        .f0          (f0),
        .data_from_dt(data_from_dt),
        .int_ack     (int_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cpu_int     (cpu_int),
        .overrun     (overrun),
        .sync_err    (sync_err),
        .in_sync     (in_sync)
    );

    initial forever #5 c4 = ~c4;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position within the frame (-1 = hunting), captured bits,
    // and the bytes of the most recently completed frame.
    int         m_pos = -1;
    int         m_miss = 0;
    bit         m_bits [SLOTS*8];
    logic [7:0] m_vis [SLOTS];
    bit         m_vis_ok = 0;
    bit         m_int = 0, m_ovr = 0, m_serr = 0, m_sync = 0;
    logic [7:0] m_rd = '0;
    bit         m_rd_ok = 1;

    initial forever begin
        bit done;
        @(posedge c4 or negedge reset_in_rg);
        done = 0;
        if (!reset_in_rg) begin
            m_pos = -1; m_miss = 0; m_vis_ok = 0;
            m_int = 0; m_ovr = 0; m_serr = 0; m_sync = 0;
            m_rd = '0; m_rd_ok = 1;
        end else begin
            m_rd_ok = m_vis_ok;
            m_rd = m_vis[rd_addr];
            m_serr = 0;
            if (m_pos < 0) begin
                if (!f0) begin m_pos = 0; m_sync = 1; m_miss = 0; end
            end else begin
                if (m_pos % CPB == CPB - 1) m_bits[m_pos / CPB] = data_from_dt;
                if (m_pos == FL - 1) begin
                    m_pos = 0;
                    if (!f0) begin
                        m_miss = 0; done = 1;
                    end else begin
                        m_miss++;
                        if (m_miss >= MISS) begin m_pos = -1; m_sync = 0; m_miss = 0; end
                        else done = 1;
                    end
                end else if (!f0) begin
                    m_serr = 1; m_pos = 0; m_miss = 0;
                end else begin
                    m_pos++;
                end
            end
            if (done) begin
                for (int k = 0; k < SLOTS; k++) begin
                    logic [7:0] v;
                    v = '0;
                    for (int b = 0; b < 8; b++) v = {v[6:0], m_bits[k*8 + b]};
                    m_vis[k] = v;
                end
                m_vis_ok = 1;
                m_ovr = !int_ack && (m_ovr || m_int);
                m_int = 1;
            end else if (int_ack) begin
                m_int = 0; m_ovr = 0;
            end
        end
    end

    initial forever begin
        @(negedge c4);
        if (reset_in_rg) begin
            chk("cpu_int", int'(cpu_int), int'(m_int));
            chk("overrun", int'(overrun), int'(m_ovr));
            chk("sync_err", int'(sync_err), int'(m_serr));
            chk("in_sync", int'(in_sync), int'(m_sync));
            if (m_rd_ok) chk("rd_data", int'(rd_data), int'(m_rd));
        end
    end

    task automatic step(input logic f, input logic d, input logic a, input int addr);
        @(negedge c4);
        f0 = f; data_from_dt = d; int_ack = a; rd_addr = AW'(addr);
    endtask

    task automatic fill(input int base);
        for (int k = 0; k < SLOTS; k++)
            pay[k] = (base < 0) ? 8'($urandom) : 8'(base + k);
    endtask

    // Cycles from..to-1 of a frame; reads cycle through slots, and when
    // base >= 0 the first SLOTS reads are pinned to base+slot.
    task automatic frame(input int from, input int to, input bit fe,
                         input int ack_at, input int base);
        for (int i = from; i < to; i++) begin
            step(!(fe && i == FL - 1), pay[i / SC][7 - (i % SC) / CPB],
                 i == ack_at, i % SLOTS);
            if (base >= 0 && i >= 1 && i <= SLOTS)
                chk("rd_lit", int'(rd_data), (base + i - 1) & 255);
        end
    endtask

    task automatic after_edge();
        @(posedge c4);
        #1;
    endtask

    initial begin
        int tp;
        #1 reset_in_rg = 1'b0;
        #1;
        chk("rst_int", int'(cpu_int), 0);
        chk("rst_sync", int'(in_sync), 0);
        chk("rst_rd", int'(rd_data), 0);
        repeat (2) @(negedge c4);
        reset_in_rg = 1'b1;

        // Basic frame and readback
        step(1'b0, 1'b0, 1'b0, 0);
        fill(8'h40);
        frame(0, FL, 1, -1, -1);
        after_edge();
        chk("t1_int", int'(cpu_int), 1);
        chk("t1_sync", int'(in_sync), 1);

        // Second frame without ack: overrun, then ack clears both
        fill(-1);
        frame(0, FL, 1, -1, 8'h40);
        after_edge();
        chk("t2_ovr", int'(overrun), 1);
        frame(0, 1, 1, 0, -1);
        after_edge();
        chk("t2_ack_int", int'(cpu_int), 0);
        chk("t2_ack_ovr", int'(overrun), 0);
        frame(1, FL, 1, -1, -1);

        // Early f0 realigns and discards the partial frame
        fill(8'hA0);
        frame(0, 100, 1, 0, -1);
        step(1'b0, 1'b0, 1'b0, 0);
        after_edge();
        chk("t3_serr", int'(sync_err), 1);
        chk("t3_noint", int'(cpu_int), 0);
        frame(0, 1, 1, -1, -1);
        after_edge();
        chk("t3_serr_off", int'(sync_err), 0);
        frame(1, FL, 1, -1, -1);
        after_edge();
        chk("t3_int", int'(cpu_int), 1);
        fill(8'h10);
        frame(0, FL, 1, 0, 8'hA0);

        // f0 stops: one swap, then sync lost with no swap
        fill(8'h60);
        frame(0, FL, 0, 0, -1);
        after_edge();
        chk("t4_int", int'(cpu_int), 1);
        chk("t4_sync1", int'(in_sync), 1);
        fill(8'hC0);
        frame(0, FL, 0, -1, -1);
        after_edge();
        chk("t4_lost", int'(in_sync), 0);
        for (int j = 0; j <= SLOTS; j++) begin
            step(1'b1, 1'($urandom), 1'b0, j % SLOTS);
            if (j > 0) chk("t4_rd", int'(rd_data), 8'h60 + j - 1);
        end
        step(1'b0, 1'b0, 1'b0, 0);
        after_edge();
        chk("t4_resync", int'(in_sync), 1);

        // Ack coincident with frame end: set wins
        fill(-1);
        frame(0, FL, 1, FL - 1, -1);
        after_edge();
        chk("t5_int", int'(cpu_int), 1);
        chk("t5_ovr", int'(overrun), 0);

        // Asynchronous reset mid-frame
        frame(0, 200, 1, -1, -1);
        @(posedge c4);
        #2 reset_in_rg = 1'b0;
        #1;
        chk("t6_int", int'(cpu_int), 0);
        chk("t6_ovr", int'(overrun), 0);
        chk("t6_serr", int'(sync_err), 0);
        chk("t6_sync", int'(in_sync), 0);
        chk("t6_rd", int'(rd_data), 0);
        @(negedge c4);
        reset_in_rg = 1'b1;
        for (int j = 0; j < 600; j++)
            step(1'b1, 1'($urandom), 1'b0, $urandom_range(SLOTS - 1));
        #1;
        chk("t6_noint", int'(cpu_int), 0);
        chk("t6_hunt", int'(in_sync), 0);

        // Random traffic: mostly well-formed frames, some misses and early f0
        tp = 0;
        for (int c = 0; c < 10000; c++) begin
            logic f;
            int   r;
            r = int'($urandom_range(999));
            f = 1'b1;
            if (tp == FL - 1 && r < 850) f = 1'b0;
            if (tp != FL - 1 && r == 7) f = 1'b0;
            step(f, 1'($urandom), $urandom_range(299) == 0, $urandom_range(SLOTS - 1));
            tp = (!f) ? 0 : (tp + 1) % FL;
        end
        repeat (2) @(negedge c4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
